spi_master_core: RTL and testbench
==================================

# spi_master_core

Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0, MSB first) bridging a simple enable/data/done handshake on the system clock to a 4-wire SPI bus. It sits between a local controller (e.g. flash command sequencer) and an external SPI slave. It transmits or receives back-to-back bytes while an enable is held, keeping chip-select low across consecutive bytes.

## Interface
- CLK_DIV, 1: system clocks per SCK half-period (≥1); SCK = I_clk / (2·CLK_DIV).
- I_clk  in  1  system clock, all logic on rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_tx_en  in  1  transmit enable; held high for continuous byte transmission.
- I_rx_en  in  1  receive enable; held high for continuous byte reception.
- I_data_in  in  8  byte to transmit; latched at start of each byte.
- O_data_out  out  8  last received byte.
- O_tx_done  out  1  one-clock pulse on the final clock of each transmitted byte.
- O_rx_done  out  1  one-clock pulse on the final clock of each received byte.
- I_spi_miso  in  1  serial data from slave.
- O_spi_sck  out  1  SPI clock, idles low.
- O_spi_cs  out  1  chip select, active low.
- O_spi_mosi  out  1  serial data to slave.

## Operation
- States: IDLE, XFER. Mode selected at byte start: TX if I_tx_en=1 (priority), else RX if I_rx_en=1.
- IDLE: CS=1, SCK=0, MOSI=0. When I_tx_en or I_rx_en sampled high → XFER, half-count h=0, CS=0, shift reg ← I_data_in (TX).
- XFER: 16 half-periods h=0..15, each CLK_DIV clocks. Even h: SCK=0, MOSI = shift bit (7−h/2), MSB first. Odd h: SCK=1. RX mode: MOSI=0.
- MISO sampled on the clock edge where SCK rises (entry to odd h), shifted in MSB first.
- Last clock of h=15: TX → O_tx_done=1; RX → O_rx_done=1 and O_data_out ← assembled byte (same edge).
- Following edge: if an enable still high → new byte, h=0, CS stays low, re-latch I_data_in, re-select mode; else → IDLE (CS=1, SCK=0, MOSI=0).
- Enable dropped mid-byte: current byte completes, done pulses, then IDLE. No partial bytes.
- O_data_out holds value until next completed receive.
- Reset (any time, incl. mid-byte): immediate IDLE; CS=1, SCK=0, MOSI=0, O_tx_done=0, O_rx_done=0, O_data_out=8'h00, counters cleared.

## Timing
- All outputs registered.
- CS falls on first rising edge where an enable is sampled high; MOSI bit7 valid same edge, SCK low for CLK_DIV clocks before first rising SCK.
- Byte duration: 16·CLK_DIV clocks; back-to-back bytes have no gap (CLK_DIV=1: exactly 16 clocks per byte, done pulse every 16 clocks).
- Done pulse is exactly 1 clock wide, asserted during the final clock of the byte (SCK high). Controller updating I_data_in on the edge ending the done pulse gets the new value used for the next byte.
- CS rises 1 clock after final done pulse.

## Configuration
- SPI_FULL_DUPLEX_EN: when defined, TX mode also samples MISO; O_data_out updates and O_rx_done pulses simultaneously with O_tx_done. When undefined, TX mode ignores MISO, O_data_out/O_rx_done change only in RX mode.

## Test plan
- Reset held, then I_tx_en=1, I_data_in=8'hA5, CLK_DIV=1 → CS falls on first edge, MOSI shows 1,0,1,0,0,1,0,1 across 8 SCK periods sampled at SCK rise, O_tx_done one-clock pulse at clock 16.
- Continuous TX with controller incrementing I_data_in on each O_tx_done from 8'h00 to 8'hFF, then dropping I_tx_en → CS low throughout, each byte equals previous+1, done every 16 clocks, CS high one clock after final done.
- I_rx_en=1 only, slave drives 8'h3C mode-0 on MISO → MOSI=0, O_rx_done pulse, O_data_out=8'h3C on same edge, held after.
- I_tx_en and I_rx_en both high → TX byte performed; O_rx_done stays 0 without SPI_FULL_DUPLEX_EN; with it, MISO 8'hC3 yields O_data_out=8'hC3 with O_rx_done coincident with O_tx_done.
- I_tx_en dropped at h=6 → byte completes, O_tx_done pulses, then IDLE.
- I_rst_n asserted at h=9 → CS=1, SCK=0, MOSI=0, done=0, O_data_out=8'h00 immediately; CLK_DIV=3 rerun → SCK half-period 3 clocks, byte 48 clocks.

Source files
------------

// File: rtl/spi_master_core.sv
// Mode-0 byte SPI master: streams back-to-back bytes while I_tx_en/I_rx_en is held.
// Optional `SPI_FULL_DUPLEX_EN: TX bytes also capture MISO and pulse O_rx_done.
module spi_master_core #(
  parameter int CLK_DIV = 1
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_tx_en,
  input  logic       I_rx_en,
  input  logic [7:0] I_data_in,
  output logic [7:0] O_data_out,
  output logic       O_tx_done,
  output logic       O_rx_done,
  input  logic       I_spi_miso,
  output logic       O_spi_sck,
  output logic       O_spi_cs,
  output logic       O_spi_mosi
);

  localparam int DATA_W = 8;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

`ifdef SPI_FULL_DUPLEX_EN
  localparam logic FULL_DUPLEX = 1'b1;
`else
  localparam logic FULL_DUPLEX = 1'b0;
`endif

  logic [0:0]        state;
  logic [3:0]        h_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              mode_tx;
  logic [DATA_W-1:0] tx_byte;
  logic [DATA_W-1:0] rx_shift;

  logic              div_wrap;
  logic              byte_end;
  logic              start;
  logic              sck_rise;
  logic              rx_active;
  logic              sample_en;
  logic              done_nxt;
  logic [3:0]        h_nxt;
  logic [DIV_W-1:0]  div_nxt;
  logic [DATA_W-1:0] rx_nxt;

  always_comb begin
    div_wrap  = (div_cnt == DIV_LAST);
    byte_end  = (state == ST_XFER) && (h_cnt == 4'd15) && div_wrap;
    start     = ((state == ST_IDLE) || byte_end) && (I_tx_en || I_rx_en);
    h_nxt     = h_cnt;
    div_nxt   = div_cnt;
    if ((state == ST_XFER) && !byte_end) begin
      if (div_wrap) begin
        h_nxt   = h_cnt + 4'd1;
        div_nxt = '0;
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end
    // MISO is captured on the same system edge that drives SCK high
    sck_rise  = (state == ST_XFER) && div_wrap && !h_cnt[0];
    rx_active = !mode_tx || FULL_DUPLEX;
    sample_en = sck_rise && rx_active;
    rx_nxt    = sample_en ? {rx_shift[DATA_W-2:0], I_spi_miso} : rx_shift;
    // done lands on the edge that opens the byte's final system clock
    done_nxt  = (state == ST_XFER) && !byte_end && (h_nxt == 4'd15) &&
                (div_nxt == DIV_LAST);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state      <= ST_IDLE;
      h_cnt      <= '0;
      div_cnt    <= '0;
      mode_tx    <= 1'b0;
      O_spi_cs   <= 1'b1;
      O_spi_sck  <= 1'b0;
      O_spi_mosi <= 1'b0;
      O_tx_done  <= 1'b0;
      O_rx_done  <= 1'b0;
      O_data_out <= '0;
    end else begin
      O_tx_done <= done_nxt && mode_tx;
      O_rx_done <= done_nxt && rx_active;
      if (done_nxt && rx_active) begin
        O_data_out <= rx_nxt;
      end
      if (start) begin
        state      <= ST_XFER;
        h_cnt      <= '0;
        div_cnt    <= '0;
        mode_tx    <= I_tx_en;
        O_spi_cs   <= 1'b0;
        O_spi_sck  <= 1'b0;
        O_spi_mosi <= I_tx_en ? I_data_in[DATA_W-1] : 1'b0;
      end else if (byte_end) begin
        state      <= ST_IDLE;
        h_cnt      <= '0;
        div_cnt    <= '0;
        O_spi_cs   <= 1'b1;
        O_spi_sck  <= 1'b0;
        O_spi_mosi <= 1'b0;
      end else if (state == ST_XFER) begin
        h_cnt   <= h_nxt;
        div_cnt <= div_nxt;
        if (div_wrap) begin
          O_spi_sck <= h_nxt[0];
          if (!h_nxt[0]) begin
            O_spi_mosi <= mode_tx ? tx_byte[~h_nxt[3:1]] : 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (start) begin
      tx_byte <= I_data_in;
    end
    rx_shift <= rx_nxt;
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: CLK_DIV=1 instance with a mode-0 slave model
// and byte scoreboard, plus a CLK_DIV=3 instance for divider timing.
module tb_spi_master_core;

`ifdef SPI_FULL_DUPLEX_EN
  localparam bit FD = 1'b1;
`else
  localparam bit FD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0, rx_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tx_done, rx_done;
  logic       miso = 1'b0;
  logic       sck, cs, mosi;

  logic       tx_en3 = 1'b0, rx_en3 = 1'b0;
  logic [7:0] data_out3;
  logic       tx_done3, rx_done3;
  logic       miso3 = 1'b0;
  logic       sck3, cs3, mosi3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] slave_byte = 8'h00;

  always #5 clk = ~clk;

  spi_master_core #(.CLK_DIV(1)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_tx_en(tx_en), .I_rx_en(rx_en),
    .I_data_in(data_in), .O_data_out(data_out), .O_tx_done(tx_done),
    .O_rx_done(rx_done), .I_spi_miso(miso), .O_spi_sck(sck),
    .O_spi_cs(cs), .O_spi_mosi(mosi)
  );

  spi_master_core #(.CLK_DIV(3)) dut3 (
    .I_clk(clk), .I_rst_n(rst_n), .I_tx_en(tx_en3), .I_rx_en(rx_en3),
    .I_data_in(data_in), .O_data_out(data_out3), .O_tx_done(tx_done3),
    .O_rx_done(rx_done3), .I_spi_miso(miso3), .O_spi_sck(sck3),
    .O_spi_cs(cs3), .O_spi_mosi(mosi3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 = tx_done, 1 = rx_done, 2 = tx_done3
  task automatic wait_done(input int sel, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      @(posedge clk); #1;
      n++;
      case (sel)
        0:       d = tx_done;
        1:       d = rx_done;
        default: d = tx_done3;
      endcase
    end
    if (!d) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor + slave model for the CLK_DIV=1 instance
  logic [7:0] mon_bits = 8'h00;
  logic [2:0] rise_cnt = 3'd0;
  logic       prev_sck = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] popped;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits  = 8'h00;
      rise_cnt  = 3'd0;
      prev_sck  = 1'b0;
      prev_done = 1'b0;
      miso      = slave_byte[7];
    end else begin
      if (sck && !prev_sck) begin
        mon_bits = {mon_bits[6:0], mosi};
        rise_cnt = rise_cnt + 3'd1;
      end
      prev_sck = sck;
      miso = slave_byte[~rise_cnt];
      if (tx_done) begin
        if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else begin
          popped = exp_tx.pop_front();
          check("tx_byte", mon_bits, popped);
        end
      end
      if (rx_done) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else begin
          popped = exp_rx.pop_front();
          check("rx_byte", data_out, popped);
        end
        if (!tx_done) check("rx_mosi", mon_bits, 32'd0);
      end
      if (tx_done || rx_done) begin
        check("done_width", prev_done, 32'd0);
        mon_bits = 8'h00;
      end
      prev_done = tx_done || rx_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int run;
    logic prev3;
    logic [7:0] bits3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_data_out", data_out, 8'h00);
    rst_n = 1'b1;

    // Single TX byte 0xA5
    @(posedge clk); #1;
    tx_en = 1'b1; data_in = 8'hA5; exp_tx.push_back(8'hA5);
    @(posedge clk); #1;
    check("a5_cs_fall", cs, 0);
    check("a5_mosi_b7", mosi, 1);
    check("a5_sck_low", sck, 0);
    wait_done(0, n);
    check("a5_done_clk", n + 1, 16);
    tx_en = 1'b0;
    @(posedge clk); #1;
    check("a5_cs_rise", cs, 1);
    check("a5_done_clear", tx_done, 0);
    check("a5_idle_mosi", mosi, 0);

    // Continuous TX 0x00..0xFF
    @(posedge clk); #1;
    tx_en = 1'b1; data_in = 8'h00; exp_tx.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      wait_done(0, n);
      check("cont_period", n, 16);
      check("cont_cs_low", cs, 0);
      if (i < 255) begin
        data_in = 8'(i + 1);
        exp_tx.push_back(8'(i + 1));
      end else begin
        tx_en = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("cont_cs_rise", cs, 1);

    // RX byte 0x3C
    @(posedge clk); #1;
    slave_byte = 8'h3C; rx_en = 1'b1; exp_rx.push_back(8'h3C);
    wait_done(1, n);
    check("rx_done_clk", n, 16);
    check("rx_data_same_edge", data_out, 8'h3C);
    check("rx_no_tx_done", tx_done, 0);
    rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rx_data_held", data_out, 8'h3C);
    check("rx_cs_idle", cs, 1);

    // Both enables: TX wins
    @(posedge clk); #1;
    slave_byte = 8'hC3; tx_en = 1'b1; rx_en = 1'b1; data_in = 8'h5A;
    exp_tx.push_back(8'h5A);
    if (FD) exp_rx.push_back(8'hC3);
    wait_done(0, n);
    check("both_done_clk", n, 16);
    check("both_rx_done", rx_done, FD);
    check("both_data_out", data_out, FD ? 8'hC3 : 8'h3C);
    tx_en = 1'b0; rx_en = 1'b0;
    @(posedge clk); #1;
    check("both_cs_rise", cs, 1);

    // Enable dropped at h=6
    @(posedge clk); #1;
    tx_en = 1'b1; data_in = 8'h96; exp_tx.push_back(8'h96);
    repeat (7) @(posedge clk);
    #1;
    tx_en = 1'b0;
    wait_done(0, n);
    check("drop_done_clk", n + 7, 16);
    @(posedge clk); #1;
    check("drop_cs_rise", cs, 1);
    repeat (2) @(posedge clk);
    #1;
    check("drop_stays_idle", cs, 1);

    // Reset at h=9
    @(posedge clk); #1;
    tx_en = 1'b1; data_in = 8'h0F;
    repeat (10) @(posedge clk);
    #1;
    check("mid_sck_high", sck, 1);
    check("mid_cs_low", cs, 0);
    rst_n = 1'b0; tx_en = 1'b0;
    #1;
    check("arst_cs", cs, 1);
    check("arst_sck", sck, 0);
    check("arst_mosi", mosi, 0);
    check("arst_tx_done", tx_done, 0);
    check("arst_rx_done", rx_done, 0);
    check("arst_data_out", data_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", cs, 1);

    // CLK_DIV=3 instance
    tx_en3 = 1'b1; data_in = 8'hB2;
    @(posedge clk); #1;
    check("div3_cs_fall", cs3, 0);
    check("div3_sck_low", sck3, 0);
    check("div3_mosi_b7", mosi3, 1);
    cyc = 1; run = 1; prev3 = 1'b0; bits3 = 8'h00;
    while (!tx_done3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (sck3 !== prev3) begin
        check("div3_half", run, 3);
        if (sck3) bits3 = {bits3[6:0], mosi3};
        run = 1;
      end else begin
        run++;
      end
      prev3 = sck3;
    end
    check("div3_byte_clks", cyc, 48);
    check("div3_mosi_byte", bits3, 8'hB2);
    tx_en3 = 1'b0;
    @(posedge clk); #1;
    check("div3_cs_rise", cs3, 1);

    check("tx_queue_empty", exp_tx.size(), 0);
    check("rx_queue_empty", exp_rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
